cred_rom_arbiter: RTL and testbench

Two-port arbiter and read sequencer that shares one synchronous credential ROM (the user-ID or password table) between two requesters: the ID matcher and the password matcher of the login path. It accepts level requests with an address, selects one requester, drives the ROM address, waits out the ROM read latency, and returns the word with a one-cycle valid strobe to the winner only. It sits between the access-control FSM and the ROM instance.

---
 rtl/cred_rom_arbiter.sv | 125 ++++++++++++
 tb/tb_cred_rom_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cred_rom_arbiter.sv
// Two-requester arbiter and read sequencer sharing one synchronous credential ROM.
// Define CRA_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module cred_rom_arbiter #(
    parameter int AW     = 3,
    parameter int DW     = 20,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          win_q, win_d;
    logic [AW-1:0] addr_d;
    logic          gnt0_d, gnt1_d, rv0_d, rv1_d, cap;
    logic          pick;

`ifdef CRA_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie, serve whoever did not win the previous grant.
    always_comb begin
        if (req0 && req1) pick = ~last_q;
        else              pick = req1;
    end
`else
    always_comb pick = req1 & ~req0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        addr_d  = rom_addr;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        cap     = 1'b0;
`ifdef CRA_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d   = pick;
                    addr_d  = pick ? addr1 : addr0;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    cnt_d   = 2'd0;
                    state_d = WAIT;
`ifdef CRA_ROUND_ROBIN_EN
                    last_d  = pick;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == 2'(RD_LAT)) begin
                    cap     = 1'b1;
                    rv0_d   = ~win_q;
                    rv1_d   = win_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            win_q    <= 1'b0;
            rom_addr <= '0;
            rdata    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            rom_addr <= addr_d;
            gnt0     <= gnt0_d;
            gnt1     <= gnt1_d;
            rvalid0  <= rv0_d;
            rvalid1  <= rv1_d;
            busy     <= (state_d != IDLE);
            if (cap) rdata <= rom_q;
        end
    end

`ifdef CRA_ROUND_ROBIN_EN
    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_cred_rom_arbiter.sv
// Directed bench for cred_rom_arbiter: one RD_LAT=1 instance and one RD_LAT=2 instance.
module tb_cred_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0, req1;
    logic [2:0]  addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [19:0] rdata, rom_q;
    logic [2:0]  rom_addr;

    logic        req0b, req1b;
    logic [2:0]  addr0b, addr1b;
    logic        gnt0b, gnt1b, rvalid0b, rvalid1b, busyb;
    logic [19:0] rdatab, rom_qb;
    logic [2:0]  rom_addrb;

    logic [19:0] rom [8];

    assign rom_q = rom[rom_addr];
    always @(posedge clk) rom_qb <= rom[rom_addrb];

    cred_rom_arbiter #(.AW(3), .DW(20), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .rom_addr(rom_addr), .rom_q(rom_q), .busy(busy)
    );

    cred_rom_arbiter #(.AW(3), .DW(20), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0(req0b), .addr0(addr0b), .req1(req1b), .addr1(addr1b),
        .gnt0(gnt0b), .gnt1(gnt1b), .rvalid0(rvalid0b), .rvalid1(rvalid1b),
        .rdata(rdatab), .rom_addr(rom_addrb), .rom_q(rom_qb), .busy(busyb)
    );

    int passes = 0;
    int total  = 0;
    int fails  = 0;
    int busy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rom[0] = 20'hA1000; rom[1] = 20'hB2001; rom[2] = 20'hC3002; rom[3] = 20'hD4003;
        rom[4] = 20'hE5004; rom[5] = 20'hF6005; rom[6] = 20'h07006; rom[7] = 20'h18007;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        req0b = 0; req1b = 0; addr0b = 0; addr1b = 0;

        // reset values
        step(); step();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rv0", 32'(rvalid0), 0);
        chk("rst_rv1", 32'(rvalid1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_busyb", 32'(busyb), 0);

        // single request, RD_LAT=1
        rst = 0; req0 = 1; addr0 = 3'd2;
        step();
        chk("s_gnt0", 32'(gnt0), 1);
        chk("s_gnt1", 32'(gnt1), 0);
        chk("s_addr", 32'(rom_addr), 2);
        chk("s_busy", 32'(busy), 1);
        step();
        chk("s_gnt0_pulse", 32'(gnt0), 0);
        chk("s_rv0_early", 32'(rvalid0), 0);
        step();
        chk("s_rv0", 32'(rvalid0), 1);
        chk("s_rv1", 32'(rvalid1), 0);
        chk("s_rdata", 32'(rdata), 32'hC3002);
        chk("s_busy_done", 32'(busy), 1);
        req0 = 0;
        step();
        chk("s_rv0_pulse", 32'(rvalid0), 0);
        chk("s_busy_idle", 32'(busy), 0);
        chk("s_rdata_hold", 32'(rdata), 32'hC3002);

        // tie from a fresh reset; req0 re-requests after its first read
        rst = 1; step(); rst = 0;
        req0 = 1; addr0 = 3'd1; req1 = 1; addr1 = 3'd4;
        step();
        chk("t1_gnt0", 32'(gnt0), 1);
        chk("t1_gnt1", 32'(gnt1), 0);
        chk("t1_addr", 32'(rom_addr), 1);
        step();
        step();
        chk("t1_rv0", 32'(rvalid0), 1);
        chk("t1_rdata", 32'(rdata), 32'hB2001);
        step();
        chk("t1_done_nog0", 32'(gnt0), 0);
        chk("t1_done_nog1", 32'(gnt1), 0);
        step();
`ifdef CRA_ROUND_ROBIN_EN
        chk("t2_gnt1", 32'(gnt1), 1);
        chk("t2_gnt0", 32'(gnt0), 0);
        chk("t2_addr", 32'(rom_addr), 4);
        step(); step();
        chk("t2_rv1", 32'(rvalid1), 1);
        chk("t2_rdata", 32'(rdata), 32'hE5004);
        req1 = 0;
        step(); step();
        chk("t3_gnt0", 32'(gnt0), 1);
        chk("t3_addr", 32'(rom_addr), 1);
        step(); step();
        chk("t3_rv0", 32'(rvalid0), 1);
        chk("t3_rdata", 32'(rdata), 32'hB2001);
        req0 = 0;
`else
        chk("t2_gnt0", 32'(gnt0), 1);
        chk("t2_gnt1", 32'(gnt1), 0);
        chk("t2_addr", 32'(rom_addr), 1);
        step(); step();
        chk("t2_rv0", 32'(rvalid0), 1);
        chk("t2_rdata", 32'(rdata), 32'hB2001);
        req0 = 0;
        step(); step();
        chk("t3_gnt1", 32'(gnt1), 1);
        chk("t3_addr", 32'(rom_addr), 4);
        step(); step();
        chk("t3_rv1", 32'(rvalid1), 1);
        chk("t3_rdata", 32'(rdata), 32'hE5004);
        req1 = 0;
`endif
        step();

        // address latched at grant; held request is served again after DONE
        req1 = 1; addr1 = 3'd4;
        step();
        chk("a_gnt1", 32'(gnt1), 1);
        chk("a_addr", 32'(rom_addr), 4);
        step();
        addr1 = 3'd7;
        step();
        chk("a_rv1", 32'(rvalid1), 1);
        chk("a_rdata", 32'(rdata), 32'hE5004);
        chk("a_addr_hold", 32'(rom_addr), 4);
        step();
        chk("a_idle_nog1", 32'(gnt1), 0);
        step();
        chk("a2_gnt1", 32'(gnt1), 1);
        chk("a2_addr", 32'(rom_addr), 7);
        step(); step();
        chk("a2_rv1", 32'(rvalid1), 1);
        chk("a2_rdata", 32'(rdata), 32'h18007);
        req1 = 0;
        step();

        // reset during WAIT aborts the read
        req0 = 1; addr0 = 3'd6;
        step();
        chk("r_gnt0", 32'(gnt0), 1);
        step();
        #2 rst = 1; req0 = 0;
        #1;
        chk("r_busy", 32'(busy), 0);
        chk("r_addr", 32'(rom_addr), 0);
        chk("r_rdata", 32'(rdata), 0);
        step();
        chk("r_norv0", 32'(rvalid0), 0);
        step();
        chk("r_norv0b", 32'(rvalid0), 0);
        rst = 0; req0 = 1; addr0 = 3'd3;
        step();
        chk("r2_gnt0", 32'(gnt0), 1);
        chk("r2_addr", 32'(rom_addr), 3);
        step(); step();
        chk("r2_rv0", 32'(rvalid0), 1);
        chk("r2_rdata", 32'(rdata), 32'hD4003);
        req0 = 0;
        step();

        // RD_LAT=2 instance
        req1b = 1; addr1b = 3'd5;
        busy_cnt = 0;
        step();
        chk("l2_gnt1", 32'(gnt1b), 1);
        chk("l2_addr", 32'(rom_addrb), 5);
        if (busyb) busy_cnt++;
        step();
        chk("l2_rv1_c2", 32'(rvalid1b), 0);
        if (busyb) busy_cnt++;
        step();
        chk("l2_rv1_c3", 32'(rvalid1b), 0);
        if (busyb) busy_cnt++;
        step();
        chk("l2_rv1", 32'(rvalid1b), 1);
        chk("l2_rv0", 32'(rvalid0b), 0);
        chk("l2_rdata", 32'(rdatab), 32'hF6005);
        if (busyb) busy_cnt++;
        req1b = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busyb) busy_cnt++;
        end
        chk("l2_busy_cycles", 32'(busy_cnt), 4);
        chk("l2_idle", 32'(busyb), 0);
        chk("l1_never_rv_after", 32'(rvalid1 | rvalid0), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
